flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 3: number of requester ports (2..4).
REQ-002 SHALL have parameter TIMEOUT, default 8'd200: max iclk cycles waiting for flash ack.
REQ-003 SHALL have parameter CACHE_EN, default 1: enables the one-word last-read cache.
REQ-004 SHALL have port iclk  in  1  sole clock; all state on posedge iclk.
REQ-005 SHALL have port ireset_n  in  1  reset; asynchronous and active-low.
REQ-006 SHALL have port ireq  in  NPORT  per-port toggle request.
REQ-007 SHALL have port iaddr  in  NPORT*23  per-port byte address; port i at bits [23*i+22:23*i].
REQ-008 SHALL have port oack  out  NPORT  per-port toggle acknowledge.
REQ-009 SHALL have port odout  out  NPORT*16  per-port read word; port i at bits [16*i+15:16*i].
REQ-010 SHALL have port iflush  in  1  one-cycle pulse; invalidates the cache.
REQ-011 SHALL have port ofl_addr  out  23  byte address to the flash read controller.
REQ-012 SHALL have port ofl_req  out  1  toggle request to the flash read controller.
REQ-013 SHALL have port ifl_ack  in  1  toggle acknowledge from the flash read controller.
REQ-014 SHALL have port ifl_dout  in  16  word from the flash read controller; valid when ifl_ack==ofl_req.
REQ-015 SHALL have port oerr  out  1  one-cycle pulse on timeout.

Function
REQ-016 SHALL treat port i as pending when ireq[i]!=oack[i]; iaddr[i] SHALL be held stable by the requester while pending.
REQ-017 SHALL implement states SYNC, IDLE, WAIT.
REQ-018 SYNC (first cycle after reset release): oack<=ireq, ofl_req<=ifl_ack; then IDLE.
REQ-019 IDLE with no pending port: stay IDLE, no output changes.
REQ-020 IDLE with pending ports: grant one by round-robin, searching from (last_grant+1) mod NPORT; last_grant resets to NPORT-1, so port 0 has first priority.
REQ-021 On grant with CACHE_EN=1, cache_valid=1 and iaddr[g]==cache_addr (hit): odout[g]<=cache_data, oack[g]<=~oack[g], stay IDLE; 1-cycle latency, no flash access.
REQ-022 On grant (miss): ofl_addr<=iaddr[g], ofl_req<=~ofl_req, clear timer, go WAIT.
REQ-023 WAIT when ifl_ack==ofl_req: odout[g]<=ifl_dout, oack[g]<=~oack[g], cache_addr<=ofl_addr, cache_data<=ifl_dout, cache_valid<=1, go IDLE.
REQ-024 WAIT, timer reaching TIMEOUT before ack: odout[g]<=16'hFFFF, toggle oack[g], oerr<=1 for one cycle, cache_valid<=0, go SYNC to resync the toggle pair.
REQ-025 last_grant SHALL update on every grant, hit or miss.
REQ-026 Arbiter SHALL issue at most one flash request at a time; ofl_addr SHALL hold its value while in WAIT.
REQ-027 iflush SHALL clear cache_valid in any state; when coinciding with a REQ-023 fill, the flush wins and cache_valid ends 0.
REQ-028 A hit on port i SHALL not block a different port from being granted on the next cycle.
REQ-029 SHALL toggle only oack of the granted port; all other odout and oack hold.

Reset
REQ-030 ireset_n low SHALL asynchronously force: state=SYNC, oack=0, odout=0, ofl_req=0, ofl_addr=0, oerr=0, cache_valid=0, last_grant=NPORT-1, timer=0.
REQ-031 Reset mid-WAIT SHALL abandon the transfer; SYNC re-aligns the toggles, so no spurious ack is issued after reset release.

Structure
REQ-032 SHALL place ADDR_W=23, DATA_W=16 and the state encoding in shared package flash_pkg.
REQ-033 SHALL implement the round-robin picker as sub-module flash_rr_pick (inputs: pending vector, last_grant; outputs: any, grant index).

Verification
REQ-034 Single port 0 reads 0x000100: flash returns 0x1234 after 14 cycles -> odout[0]=0x1234 and oack[0] toggles in the same cycle; ofl_req toggles exactly once.
REQ-035 Ports 0, 1 and 2 toggle simultaneously to distinct addresses -> served in order 0,1,2; the next simultaneous burst is served in order 0,1,2 again, since last_grant=2.
REQ-036 Port 1 rereads the last address 0x000100 -> oack[1] toggles 1 cycle after ireq[1] with 0x1234, and ofl_req does not toggle; after an iflush pulse, the same read does access flash.
REQ-037 Flash never acks -> after TIMEOUT cycles, odout[g]=0xFFFF, oack[g] toggles, oerr pulses once; the following request completes normally.
REQ-038 ireset_n asserted in WAIT while ireq[0]=1 -> all outputs are 0 immediately; after release, oack[0]=1 following SYNC with no data delivered, and ofl_req equals ifl_ack.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared widths, FSM encoding and cache entry type for the flash read arbiter.
package flash_pkg;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cache_t;
endpackage

// File: rtl/flash_rr_pick.sv
// Round-robin picker: first pending port searching upward from last_grant+1.
module flash_rr_pick #(
  parameter int unsigned NPORT = 3,
  parameter int unsigned PW    = 2
) (
  input  logic [NPORT-1:0] i_pending,
  input  logic [PW-1:0]    i_last_grant,
  output logic             o_any,
  output logic [PW-1:0]    o_grant
);
  int unsigned w_idx;

  // Walk the offsets downward so the closest pending port wins the last write.
  always_comb begin
    o_any   = |i_pending;
    o_grant = '0;
    w_idx   = 0;
    for (int unsigned k = NPORT; k >= 1; k--) begin
      w_idx = 32'(i_last_grant) + k;
      if (w_idx >= NPORT) w_idx = w_idx - NPORT;
      if (i_pending[PW'(w_idx)]) o_grant = PW'(w_idx);
    end
  end
endmodule

// File: rtl/flash_arbiter.sv
// Toggle-handshake arbiter sharing one flash read controller among NPORT
// requesters, with round-robin grant, a one-word read cache and ack timeout.
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int unsigned NPORT    = 3,
  parameter logic [7:0]  TIMEOUT  = 8'd200,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                     iclk,
  input  logic                     ireset_n,
  input  logic [NPORT-1:0]         ireq,
  input  logic [NPORT*ADDR_W-1:0]  iaddr,
  output logic [NPORT-1:0]         oack,
  output logic [NPORT*DATA_W-1:0]  odout,
  input  logic                     iflush,
  output logic [ADDR_W-1:0]        ofl_addr,
  output logic                     ofl_req,
  input  logic                     ifl_ack,
  input  logic [DATA_W-1:0]        ifl_dout,
  output logic                     oerr
);
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t            r_state, w_state_nxt;
  logic [NPORT-1:0]  r_ack, w_ack_nxt;
  logic [DATA_W-1:0] r_dout [NPORT];
  logic [DATA_W-1:0] w_dout_nxt [NPORT];
  logic [ADDR_W-1:0] r_fl_addr, w_fl_addr_nxt;
  logic              r_fl_req, w_fl_req_nxt;
  logic              r_err, w_err_nxt;
  cache_t            r_cache, w_cache_nxt;
  logic [PW-1:0]     r_last_grant, w_last_grant_nxt;
  logic [PW-1:0]     r_grant, w_grant_nxt;
  logic [7:0]        r_timer, w_timer_nxt;

  logic [ADDR_W-1:0] w_addr [NPORT];
  logic [NPORT-1:0]  w_pending;
  logic              w_any;
  logic [PW-1:0]     w_pick;
  logic              w_hit;
  logic              w_fl_done;
  logic              w_timeout;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign w_addr[gi]                     = iaddr[gi*ADDR_W +: ADDR_W];
    assign odout[gi*DATA_W +: DATA_W]     = r_dout[gi];
  end

  assign w_pending = ireq ^ r_ack;
  assign w_hit     = CACHE_EN && r_cache.valid && w_any && (w_addr[w_pick] == r_cache.addr);
  assign w_fl_done = (ifl_ack == r_fl_req);
  assign w_timeout = (r_timer == TIMEOUT - 8'd1);

  flash_rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
    .i_pending    (w_pending),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_grant      (w_pick)
  );

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) r_state <= ST_SYNC;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC: w_state_nxt = ST_IDLE;
      ST_IDLE: if (w_any && !w_hit) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_fl_done)      w_state_nxt = ST_IDLE;
        else if (w_timeout) w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    w_ack_nxt        = r_ack;
    w_dout_nxt       = r_dout;
    w_fl_addr_nxt    = r_fl_addr;
    w_fl_req_nxt     = r_fl_req;
    w_err_nxt        = 1'b0;
    w_cache_nxt      = r_cache;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_timer_nxt      = r_timer;
    case (r_state)
      ST_SYNC: begin
        w_ack_nxt    = ireq;
        w_fl_req_nxt = ifl_ack;
      end
      ST_IDLE: begin
        if (w_any) begin
          w_last_grant_nxt = w_pick;
          w_grant_nxt      = w_pick;
          if (w_hit) begin
            w_dout_nxt[w_pick] = r_cache.data;
            w_ack_nxt[w_pick]  = ~r_ack[w_pick];
          end else begin
            w_fl_addr_nxt = w_addr[w_pick];
            w_fl_req_nxt  = ~r_fl_req;
            w_timer_nxt   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (w_fl_done) begin
          w_dout_nxt[r_grant] = ifl_dout;
          w_ack_nxt[r_grant]  = ~r_ack[r_grant];
          w_cache_nxt         = '{valid: 1'b1, addr: r_fl_addr, data: ifl_dout};
        end else if (w_timeout) begin
          w_dout_nxt[r_grant] = 16'hFFFF;
          w_ack_nxt[r_grant]  = ~r_ack[r_grant];
          w_err_nxt           = 1'b1;
          w_cache_nxt.valid   = 1'b0;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: ;
    endcase
    // Flush overrides a same-cycle fill.
    if (iflush) w_cache_nxt.valid = 1'b0;
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_ack        <= '0;
      for (int i = 0; i < NPORT; i++) r_dout[i] <= '0;
      r_fl_addr    <= '0;
      r_fl_req     <= 1'b0;
      r_err        <= 1'b0;
      r_cache      <= '0;
      r_last_grant <= PW'(NPORT - 1);
      r_grant      <= '0;
      r_timer      <= '0;
    end else begin
      r_ack        <= w_ack_nxt;
      r_dout       <= w_dout_nxt;
      r_fl_addr    <= w_fl_addr_nxt;
      r_fl_req     <= w_fl_req_nxt;
      r_err        <= w_err_nxt;
      r_cache      <= w_cache_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_timer      <= w_timer_nxt;
    end
  end

  assign oack     = r_ack;
  assign ofl_addr = r_fl_addr;
  assign ofl_req  = r_fl_req;
  assign oerr     = r_err;
endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a request/response model.
module tb_flash_arbiter;
  localparam int NPORT   = 3;
  localparam int TIMEOUT = 200;

  logic                iclk = 1'b0;
  logic                ireset_n = 1'b0;
  logic [NPORT-1:0]    ireq = '0;
  logic [NPORT*23-1:0] iaddr = '0;
  logic [NPORT-1:0]    oack;
  logic [NPORT*16-1:0] odout;
  logic                iflush = 1'b0;
  logic [22:0]         ofl_addr;
  logic                ofl_req;
  logic                ifl_ack = 1'b0;
  logic [15:0]         ifl_dout = '0;
  logic                oerr;

  int n_checks = 0;
  int n_err    = 0;

  flash_arbiter #(.NPORT(NPORT), .TIMEOUT(8'(TIMEOUT)), .CACHE_EN(1'b1)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq), .iaddr(iaddr), .oack(oack),
    .odout(odout), .iflush(iflush), .ofl_addr(ofl_addr), .ofl_req(ofl_req),
    .ifl_ack(ifl_ack), .ifl_dout(ifl_dout), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  // Flash contents: fixed function of the address.
  function automatic logic [15:0] memf(input logic [22:0] a);
    logic [22:0] t;
    if (a == 23'h000100) return 16'h1234;
    t = a ^ (a >> 7);
    return t[15:0] ^ 16'h5A5A;
  endfunction

  // Flash read controller model with programmable latency and a stall switch.
  int fl_lat   = 0;
  int fl_cnt   = 0;
  bit fl_stall = 1'b0;
  always @(posedge iclk) begin
    if (!fl_stall && (ofl_req != ifl_ack)) begin
      if (fl_cnt >= fl_lat) begin
        ifl_dout <= memf(ofl_addr);
        ifl_ack  <= ofl_req;
        fl_cnt   <= 0;
      end else begin
        fl_cnt <= fl_cnt + 1;
      end
    end else begin
      fl_cnt <= 0;
    end
  end

  // Observers: flash request toggles, error pulses, ack order.
  int   fl_toggles = 0;
  int   err_pulses = 0;
  int   ack_order[$];
  logic mon_fl_prev = 1'b0;
  logic [NPORT-1:0] mon_ack_prev = '0;
  always @(posedge iclk) begin
    #2;
    if (ofl_req !== mon_fl_prev) fl_toggles++;
    mon_fl_prev = ofl_req;
    if (oerr === 1'b1) err_pulses++;
    for (int p = 0; p < NPORT; p++)
      if (oack[p] !== mon_ack_prev[p]) ack_order.push_back(p);
    mon_ack_prev = oack;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input int port, input logic [22:0] addr, input bit flush,
                         output int lat, output logic [15:0] data, output int nfl,
                         output logic [NPORT-1:0] ackdiff);
    logic [NPORT-1:0] ack0;
    int fl0;
    if (flush) begin
      @(negedge iclk); iflush = 1'b1;
      @(negedge iclk); iflush = 1'b0;
    end
    @(negedge iclk);
    ack0 = oack;
    fl0  = fl_toggles;
    iaddr[port*23 +: 23] = addr;
    ireq[port] = ~ireq[port];
    lat = 0;
    while (oack == ack0 && lat < 400) begin
      @(negedge iclk);
      lat++;
    end
    data    = odout[port*16 +: 16];
    nfl     = fl_toggles - fl0;
    ackdiff = oack ^ ack0;
  endtask

  typedef struct {
    int          port;
    logic [22:0] addr;
    bit          flush;
    int          lat;
    logic [15:0] exp_data;
    bit          exp_flash;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, nfl, e0;
    logic [15:0] data;
    logic [NPORT-1:0] ackdiff, a0;
    bit   pend[NPORT];
    int   age[NPORT];
    logic [22:0] paddr[NPORT];
    logic [22:0] pool[4];
    logic [NPORT-1:0] prev_ack;
    logic [22:0] burst_addr[2][NPORT];
    int guard;

    vecs[0] = '{0, 23'h000100, 1'b0, 11, 16'h1234, 1'b1};
    vecs[1] = '{1, 23'h000100, 1'b0, 3,  16'h1234, 1'b0};
    vecs[2] = '{2, 23'h000100, 1'b1, 3,  16'h1234, 1'b1};
    vecs[3] = '{2, 23'h000200, 1'b0, 0,  memf(23'h000200), 1'b1};
    vecs[4] = '{0, 23'h000200, 1'b0, 0,  memf(23'h000200), 1'b0};
    vecs[5] = '{1, 23'h7FFFFF, 1'b0, 5,  memf(23'h7FFFFF), 1'b1};
    vecs[6] = '{1, 23'h7FFFFF, 1'b0, 5,  memf(23'h7FFFFF), 1'b0};
    vecs[7] = '{2, 23'h000000, 1'b0, 2,  memf(23'h000000), 1'b1};
    pool = '{23'h000100, 23'h000200, 23'h000300, 23'h7FFFFF};
    burst_addr[0] = '{23'h000010, 23'h000020, 23'h000030};
    burst_addr[1] = '{23'h000040, 23'h000050, 23'h000060};

    // Reset values
    #23;
    check("rst_oack", 64'(oack), 64'd0);
    check("rst_odout", 64'(odout), 64'd0);
    check("rst_ofl_req", 64'(ofl_req), 64'd0);
    check("rst_ofl_addr", 64'(ofl_addr), 64'd0);
    check("rst_oerr", 64'(oerr), 64'd0);
    @(negedge iclk); ireset_n = 1'b1;
    @(negedge iclk);

    // Directed single reads
    for (int v = 0; v < 8; v++) begin
      fl_lat = vecs[v].lat;
      do_read(vecs[v].port, vecs[v].addr, vecs[v].flush, lat, data, nfl, ackdiff);
      check($sformatf("vec%0d_data", v), 64'(data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_flash_reqs", v), 64'(nfl), 64'(vecs[v].exp_flash ? 1 : 0));
      check($sformatf("vec%0d_latency", v), 64'(lat),
            64'(vecs[v].exp_flash ? vecs[v].lat + 3 : 1));
      check($sformatf("vec%0d_ack_onehot", v), 64'(ackdiff), 64'(1 << vecs[v].port));
    end

    // Simultaneous bursts: round-robin restarts at port 0 after port 2
    fl_lat = 1;
    for (int b = 0; b < 2; b++) begin
      @(negedge iclk);
      ack_order.delete();
      a0 = oack;
      for (int p = 0; p < NPORT; p++) iaddr[p*23 +: 23] = burst_addr[b][p];
      ireq = ~ireq;
      guard = 0;
      while ((oack ^ a0) != 3'b111 && guard < 100) begin
        @(negedge iclk);
        guard++;
      end
      check($sformatf("burst%0d_count", b), 64'(ack_order.size()), 64'd3);
      for (int k = 0; k < NPORT; k++) begin
        check($sformatf("burst%0d_order%0d", b, k),
              64'(k < ack_order.size() ? ack_order[k] : -1), 64'(k));
        check($sformatf("burst%0d_data%0d", b, k), 64'(odout[k*16 +: 16]),
              64'(memf(burst_addr[b][k])));
      end
    end

    // Timeout: flash never answers
    fl_stall = 1'b1;
    e0 = err_pulses;
    do_read(1, 23'h000123, 1'b0, lat, data, nfl, ackdiff);
    check("to_data", 64'(data), 64'hFFFF);
    check("to_latency_window", 64'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 64'd1);
    check("to_ack_onehot", 64'(ackdiff), 64'b010);
    repeat (3) @(negedge iclk);
    check("to_err_pulses", 64'(err_pulses - e0), 64'd1);
    check("to_resync", 64'(ofl_req), 64'(ifl_ack));
    fl_stall = 1'b0;
    fl_lat = 2;
    do_read(1, 23'h000123, 1'b0, lat, data, nfl, ackdiff);
    check("after_to_data", 64'(data), 64'(memf(23'h000123)));
    check("after_to_flash_reqs", 64'(nfl), 64'd1);

    // Reset during WAIT with port 0 pending
    fl_stall = 1'b1;
    @(negedge iclk); ireset_n = 1'b0; ireq = '0;
    @(negedge iclk); ireset_n = 1'b1;
    repeat (2) @(negedge iclk);
    iaddr[0 +: 23] = 23'h000400;
    ireq[0] = 1'b1;
    repeat (3) @(negedge iclk);
    check("wait_no_ack", 64'(oack), 64'd0);
    #2 ireset_n = 1'b0;
    #1;
    check("mid_rst_oack", 64'(oack), 64'd0);
    check("mid_rst_odout", 64'(odout), 64'd0);
    check("mid_rst_ofl_req", 64'(ofl_req), 64'd0);
    check("mid_rst_ofl_addr", 64'(ofl_addr), 64'd0);
    check("mid_rst_oerr", 64'(oerr), 64'd0);
    @(negedge iclk); @(negedge iclk); ireset_n = 1'b1;
    @(negedge iclk);
    check("post_rst_oack", 64'(oack), 64'b001);
    check("post_rst_odout", 64'(odout), 64'd0);
    check("post_rst_fl_sync", 64'(ofl_req), 64'(ifl_ack));
    repeat (10) @(negedge iclk);
    check("post_rst_oack_hold", 64'(oack), 64'b001);
    check("post_rst_fl_hold", 64'(ofl_req), 64'(ifl_ack));
    fl_stall = 1'b0;

    // Randomized traffic against a per-port request model
    for (int p = 0; p < NPORT; p++) begin pend[p] = 1'b0; age[p] = 0; paddr[p] = '0; end
    prev_ack = oack;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge iclk);
      for (int p = 0; p < NPORT; p++) begin
        if (oack[p] != prev_ack[p]) begin
          check($sformatf("rnd_ack_was_pending_p%0d", p), 64'(pend[p]), 64'd1);
          if (pend[p])
            check($sformatf("rnd_data_p%0d", p), 64'(odout[p*16 +: 16]), 64'(memf(paddr[p])));
          pend[p] = 1'b0;
        end
      end
      prev_ack = oack;
      for (int p = 0; p < NPORT; p++) begin
        if (pend[p]) begin
          age[p]++;
          if (age[p] > 60) begin
            check($sformatf("rnd_starved_p%0d", p), 64'(age[p]), 64'd60);
            pend[p] = 1'b0;
          end
        end
      end
      if (cyc < 1000) begin
        for (int p = 0; p < NPORT; p++) begin
          if (!pend[p] && $urandom_range(3) == 0) begin
            paddr[p] = pool[$urandom_range(3)];
            iaddr[p*23 +: 23] = paddr[p];
            ireq[p] = ~ireq[p];
            pend[p] = 1'b1;
            age[p]  = 0;
          end
        end
        iflush = ($urandom_range(15) == 0);
        fl_lat = $urandom_range(5);
      end else begin
        iflush = 1'b0;
      end
    end
    for (int p = 0; p < NPORT; p++)
      check($sformatf("rnd_drained_p%0d", p), 64'(pend[p]), 64'd0);
    check("rnd_no_err", 64'(oerr), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
